i2c_target: RTL and testbench

// - I2C bus target (slave) answering one fixed 7-bit address; the far end of i2c_controller on the same sda/scl pair.
// - Oversamples scl/sda on the local clock and detects START, STOP and repeated START.
// - Receives write bytes into a byte stream, serves read bytes from a byte stream, and drives ACK/data open-drain.
// - Never stretches scl.

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_bus_sync.sv | 59 +++++
 rtl/i2c_target.sv | 211 +++++++++++++++++++++
 tb/tb_i2c_target.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared I2C definitions: 3-bit protocol state encodings (common to the
// controller and target so waveforms read the same on both ends) and the
// ACK/NACK bit levels.
// ---------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    RX_DATA  = 3'd3,
    RX_ACK   = 3'd4,
    TX_DATA  = 3'd5,
    TX_ACK   = 3'd6
  } i2c_state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// ---------------------------------------------------------------------------
// i2c_bus_sync
// Synchronises the asynchronous scl/sda bus lines into the clk domain and
// derives bus events from the synchronised values.
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   scl, sda    raw bus lines
//   sda_s       synchronised sda (used for bit sampling)
//   scl_rise    1-clk pulse on a synchronised scl rising edge
//   scl_fall    1-clk pulse on a synchronised scl falling edge
//   start_det   1-clk pulse: sda fell while scl high
//   stop_det    1-clk pulse: sda rose while scl high
// ---------------------------------------------------------------------------
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   scl_r;
  logic                   sda_r;

  // Reset to 1: an idle bus is pulled high, so leaving reset must not look
  // like an edge or a START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_r    <= 1'b1;
      sda_r    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop in the chain sample its
      // predecessor's old value, giving a true SYNC_STAGES-deep shift.
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_r    <= scl_s;
      sda_r    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  =  scl_s & ~scl_r;
  assign scl_fall  = ~scl_s &  scl_r;
  assign start_det =  scl_s &  sda_r & ~sda_s;
  assign stop_det  =  scl_s & ~sda_r &  sda_s;

endmodule

// File: rtl/i2c_target.sv
// ---------------------------------------------------------------------------
// i2c_target
// I2C target answering one 7-bit address. Receives written bytes as a
// stream (rx_data/rx_valid) and serves read bytes from a stream
// (tx_data/tx_next). Drives sda open-drain only; never stretches scl.
// Ports:
//   clk, rst    system clock (>= 8x scl), asynchronous active-high reset
//   scl         bus clock (input only)
//   sda         open-drain bus data
//   rx_data     last byte written by the controller, valid with rx_valid
//   rx_valid    1-clk pulse: new rx_data
//   tx_data     next byte to return on a read, captured when tx_next pulses
//   tx_next     1-clk pulse: tx_data captured
//   rd_nack     1-clk pulse: controller NACKed a read byte
//   busy        high from own-address ACK until STOP or START
// ---------------------------------------------------------------------------
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h6B,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_next,
  output logic       rd_nack,
  output logic       busy
);

  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;

  i2c_state_t state;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       rw;
  // ADDR_ACK/RX_ACK: set once the ACK is being driven, so the next scl fall
  // ends the ACK clock. TX_ACK: set once the controller's ACK was sampled.
  logic       ack_phase;
  logic       sda_drive_low;
  logic [7:0] shift_in;

  i2c_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign sda      = sda_drive_low ? 1'b0 : 1'bz;
  assign shift_in = {shift[6:0], sda_s};

  // The transmit shifter is loaded with bit 7 already on the wire, so the
  // remaining bits are stored one place up and padded with a 1 (release).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sda_drive_low sits on the asynchronous reset, so reset releases
      // the bus immediately without waiting for a clock edge.
      state         <= IDLE;
      bit_cnt       <= 3'd7;
      shift         <= 8'h00;
      rw            <= 1'b0;
      ack_phase     <= 1'b0;
      sda_drive_low <= 1'b0;
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      tx_next       <= 1'b0;
      rd_nack       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_next  <= 1'b0;
      rd_nack  <= 1'b0;

      if (start_det) begin
        state         <= ADDR;
        bit_cnt       <= 3'd7;
        ack_phase     <= 1'b0;
        sda_drive_low <= 1'b0;
        busy          <= 1'b0;
      end else if (stop_det) begin
        state         <= IDLE;
        ack_phase     <= 1'b0;
        sda_drive_low <= 1'b0;
        busy          <= 1'b0;
      end else begin
        case (state)
          IDLE: ;

          ADDR: begin
            if (scl_rise) begin
              shift <= shift_in;
              if (bit_cnt == 3'd0) begin
                if (shift_in[7:1] == TARGET_ADDR) begin
                  state     <= ADDR_ACK;
                  rw        <= shift_in[0];
                  ack_phase <= 1'b0;
                end else begin
                  state <= IDLE;
                end
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_drive_low <= 1'b1;
                ack_phase     <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                busy      <= 1'b1;
                bit_cnt   <= 3'd7;
                if (rw) begin
                  shift         <= {tx_data[6:0], 1'b1};
                  tx_next       <= 1'b1;
                  sda_drive_low <= ~tx_data[7];
                  state         <= TX_DATA;
                end else begin
                  sda_drive_low <= 1'b0;
                  state         <= RX_DATA;
                end
              end
            end
          end

          RX_DATA: begin
            if (scl_rise) begin
              shift <= shift_in;
              if (bit_cnt == 3'd0) begin
                rx_data   <= shift_in;
                rx_valid  <= 1'b1;
                ack_phase <= 1'b0;
                state     <= RX_ACK;
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
              end
            end
          end

          RX_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_drive_low <= 1'b1;
                ack_phase     <= 1'b1;
              end else begin
                sda_drive_low <= 1'b0;
                ack_phase     <= 1'b0;
                bit_cnt       <= 3'd7;
                state         <= RX_DATA;
              end
            end
          end

          TX_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                sda_drive_low <= 1'b0;
                ack_phase     <= 1'b0;
                state         <= TX_ACK;
              end else begin
                sda_drive_low <= ~shift[7];
                shift         <= {shift[6:0], 1'b1};
                bit_cnt       <= bit_cnt - 3'd1;
              end
            end
          end

          TX_ACK: begin
            if (scl_rise) begin
              if (sda_s == NACK) begin
                rd_nack       <= 1'b1;
                sda_drive_low <= 1'b0;
                state         <= IDLE;
              end else begin
                ack_phase <= 1'b1;
              end
            end else if (scl_fall && ack_phase) begin
              ack_phase     <= 1'b0;
              bit_cnt       <= 3'd7;
              shift         <= {tx_data[6:0], 1'b1};
              tx_next       <= 1'b1;
              sda_drive_low <= ~tx_data[7];
              state         <= TX_DATA;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// ---------------------------------------------------------------------------
// tb_i2c_target
// Bus-level controller BFM (scl = clk/8, pull-up on sda) driving i2c_target.
// Expected values come from a transaction-level model: the target ACKs only
// its own address, every written byte appears once on rx_data, every read
// returns the queued tx bytes in order.
// ---------------------------------------------------------------------------
module tb_i2c_target;

  localparam int         Q       = 20;      // quarter scl period (clk = 10)
  localparam logic [6:0] MY_ADDR = 7'h6B;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       bfm_sda_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        sda;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_next;
  logic       rd_nack;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_log[$];
  logic [7:0] tx_queue[$];
  int         tx_next_cnt = 0;
  int         rd_nack_cnt = 0;
  logic       target_drove = 1'b0;

  pullup (sda);
  assign sda = bfm_sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_target #(
    .TARGET_ADDR (MY_ADDR),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_next  (tx_next),
    .rd_nack  (rd_nack),
    .busy     (busy)
  );

  // Monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) rx_log.push_back(rx_data);
    if (tx_next) begin
      tx_next_cnt++;
      if (tx_queue.size() > 0) void'(tx_queue.pop_front());
      tx_data = (tx_queue.size() > 0) ? tx_queue[0] : 8'hFF;
    end
    if (rd_nack) rd_nack_cnt++;
    if (!bfm_sda_low && sda === 1'b0) target_drove = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got %0d checks, required completion", checks);
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic exp_ack(input logic [6:0] addr);
    return (addr == MY_ADDR) ? 1'b0 : 1'b1;
  endfunction

  // ---------------- BFM ----------------
  task automatic bit_xfer(input logic b, output logic r);
    bfm_sda_low = ~b;
    #Q; scl = 1'b1;
    #Q; r = (sda === 1'b0) ? 1'b0 : 1'b1;
    #Q; scl = 1'b0;
    #Q;
  endtask

  task automatic start_cond();
    bfm_sda_low = 1'b0;
    #Q; scl = 1'b1;
    #Q; bfm_sda_low = 1'b1;
    #Q; scl = 1'b0;
    #Q;
  endtask

  task automatic stop_cond();
    bfm_sda_low = 1'b1;
    #Q; scl = 1'b1;
    #Q; bfm_sda_low = 1'b0;
    #(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic r;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_xfer(1'b1, r);
      b = {b[6:0], r};
    end
    bit_xfer(nack, r);
  endtask

  task automatic clear_monitors();
    rx_log.delete();
    tx_next_cnt  = 0;
    rd_nack_cnt  = 0;
    target_drove = 1'b0;
  endtask

  // Full write transaction; caller clears the monitors.
  task automatic write_txn(input logic [6:0] addr, input logic [7:0] data[4], input int n);
    logic a;
    logic match;
    match = (addr == MY_ADDR);
    start_cond();
    send_byte({addr, 1'b0}, a);
    checks++;
    if (a !== exp_ack(addr)) begin
      errors++; $display("FAIL wr_addr_ack addr=%h got %b want %b", addr, a, exp_ack(addr));
    end
    for (int i = 0; i < n; i++) begin
      send_byte(data[i], a);
      checks++;
      if (a !== exp_ack(addr)) begin
        errors++; $display("FAIL wr_data_ack byte %0d got %b want %b", i, a, exp_ack(addr));
      end
    end
    #(2*Q);
    checks++;
    if (busy !== match) begin
      errors++; $display("FAIL wr_busy got %b want %b", busy, match);
    end
    checks++;
    if (rx_log.size() != (match ? n : 0)) begin
      errors++; $display("FAIL wr_rx_count got %0d want %0d", rx_log.size(), match ? n : 0);
    end else if (match) begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (rx_log[i] !== data[i]) begin
          errors++; $display("FAIL wr_rx_data byte %0d got %h want %h", i, rx_log[i], data[i]);
        end
      end
    end
    if (!match) begin
      checks++;
      if (target_drove !== 1'b0) begin
        errors++; $display("FAIL wr_foreign_drive got %b want 0", target_drove);
      end
    end
    stop_cond();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL wr_busy_after_stop got %b want 0", busy);
    end
  endtask

  // Full read transaction: ACK all bytes but the last, NACK the last.
  task automatic read_txn(input logic [6:0] addr, input logic [7:0] data[4], input int n);
    logic a;
    logic match;
    logic [7:0] b;
    logic [7:0] want;
    match = (addr == MY_ADDR);
    clear_monitors();
    tx_queue.delete();
    for (int i = 0; i < n; i++) tx_queue.push_back(data[i]);
    tx_data = data[0];
    start_cond();
    send_byte({addr, 1'b1}, a);
    checks++;
    if (a !== exp_ack(addr)) begin
      errors++; $display("FAIL rd_addr_ack addr=%h got %b want %b", addr, a, exp_ack(addr));
    end
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, b);
      want = match ? data[i] : 8'hFF;
      checks++;
      if (b !== want) begin
        errors++; $display("FAIL rd_data byte %0d got %h want %h", i, b, want);
      end
    end
    #Q;
    checks++;
    if (tx_next_cnt != (match ? n : 0)) begin
      errors++; $display("FAIL rd_tx_next_count got %0d want %0d", tx_next_cnt, match ? n : 0);
    end
    checks++;
    if (rd_nack_cnt != (match ? 1 : 0)) begin
      errors++; $display("FAIL rd_nack_count got %0d want %0d", rd_nack_cnt, match ? 1 : 0);
    end
    checks++;
    if (sda !== 1'b1) begin
      errors++; $display("FAIL rd_sda_released got %b want 1", sda);
    end
    checks++;
    if (busy !== match) begin
      errors++; $display("FAIL rd_busy got %b want %b", busy, match);
    end
    stop_cond();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rd_busy_after_stop got %b want 0", busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks += 6;
    if (rx_data  !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    if (rx_valid !== 1'b0)  begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    if (tx_next  !== 1'b0)  begin errors++; $display("FAIL reset_tx_next got %b want 0", tx_next); end
    if (rd_nack  !== 1'b0)  begin errors++; $display("FAIL reset_rd_nack got %b want 0", rd_nack); end
    if (busy     !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (sda      !== 1'b1)  begin errors++; $display("FAIL reset_sda got %b want 1", sda); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    logic [7:0] d[4] = '{8'hAA, 8'h00, 8'h00, 8'h00};
    clear_monitors();
    write_txn(MY_ADDR, d, 1);
  endtask

  task automatic test_foreign_addr();
    logic [7:0] d[4] = '{8'h55, 8'h00, 8'h00, 8'h00};
    clear_monitors();
    write_txn(7'h2A, d, 1);
  endtask

  task automatic test_read();
    logic [7:0] d[4] = '{8'h5C, 8'h81, 8'h00, 8'h00};
    read_txn(MY_ADDR, d, 2);
  endtask

  task automatic test_repeated_start();
    logic a;
    logic [7:0] b;
    clear_monitors();
    tx_queue.delete();
    tx_queue.push_back(8'hF0);
    tx_data = 8'hF0;
    start_cond();
    send_byte({MY_ADDR, 1'b0}, a);
    send_byte(8'h11, a);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL rs_write_ack got %b want 0", a); end
    start_cond();
    send_byte({MY_ADDR, 1'b1}, a);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL rs_read_addr_ack got %b want 0", a); end
    recv_byte(1'b1, b);
    checks++;
    if (b !== 8'hF0) begin errors++; $display("FAIL rs_read_data got %h want f0", b); end
    stop_cond();
    checks++;
    if (rx_log.size() != 1 || rx_log[0] !== 8'h11) begin
      errors++; $display("FAIL rs_rx got count %0d first %h want count 1 first 11",
                         rx_log.size(), (rx_log.size() > 0) ? rx_log[0] : 8'hxx);
    end
    checks++;
    if (tx_next_cnt != 1) begin errors++; $display("FAIL rs_tx_next_count got %0d want 1", tx_next_cnt); end
  endtask

  task automatic test_abort_resync();
    logic r;
    logic [7:0] d[4] = '{8'h3C, 8'h00, 8'h00, 8'h00};
    logic [7:0] abyte;
    clear_monitors();
    abyte = {MY_ADDR, 1'b0};
    start_cond();
    for (int i = 7; i >= 4; i--) bit_xfer(abyte[i], r);
    stop_cond();
    write_txn(MY_ADDR, d, 1);
  endtask

  task automatic test_random();
    logic [6:0] addr;
    logic [7:0] d[4];
    int n;
    for (int t = 0; t < 8; t++) begin
      addr = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 127)) : MY_ADDR;
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) begin
        clear_monitors();
        write_txn(addr, d, n);
      end else begin
        read_txn(addr, d, n);
      end
    end
  endtask

  task automatic test_reset_mid_ack();
    logic r;
    logic [7:0] abyte;
    abyte = {MY_ADDR, 1'b0};
    start_cond();
    for (int i = 7; i >= 0; i--) bit_xfer(abyte[i], r);
    bfm_sda_low = 1'b0;
    #Q; scl = 1'b1;
    #(Q/2);
    checks++;
    if (sda !== 1'b0) begin errors++; $display("FAIL mid_ack_driven got %b want 0", sda); end
    #3; rst = 1'b1;
    #1;
    checks++;
    if (sda !== 1'b1) begin errors++; $display("FAIL mid_ack_sda_release got %b want 1", sda); end
    checks += 5;
    if (rx_data  !== 8'h00) begin errors++; $display("FAIL mid_rst_rx_data got %h want 00", rx_data); end
    if (rx_valid !== 1'b0)  begin errors++; $display("FAIL mid_rst_rx_valid got %b want 0", rx_valid); end
    if (tx_next  !== 1'b0)  begin errors++; $display("FAIL mid_rst_tx_next got %b want 0", tx_next); end
    if (rd_nack  !== 1'b0)  begin errors++; $display("FAIL mid_rst_rd_nack got %b want 0", rd_nack); end
    if (busy     !== 1'b0)  begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #Q; scl = 1'b0;
    #Q;
    stop_cond();
  endtask

  initial begin
    test_reset();
    test_write();
    test_foreign_addr();
    test_read();
    test_repeated_start();
    test_abort_resync();
    test_random();
    test_reset_mid_ack();
    // Bus must still work after the mid-transfer reset.
    test_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
